menu_blit_ctrl: RTL

Sequencer that draws the game-select menu screen from the eight 1-bit menu sprite ROMs (title, three game icons, three game captions, A/B prompt) into the 320x240 VGA framebuffer. On a start pulse it walks a fixed sprite table. For each sprite it drives the ROM address and the select/mux for the addressed ROM, then emits one framebuffer plot per pixel with a colour chosen by sprite and by the highlighted game. It sits between the menu FSM (which supplies `start` and `sel`) and the VGA adapter write port.

---
 rtl/menu_pkg.sv | 67 ++++++
 rtl/menu_sprite_walker.sv | 50 +++++
 rtl/menu_blit_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/menu_pkg.sv
// Shared constants for the menu blitter: sprite table, colours and FSM states.
// Sprite geometry is exposed as small lookup functions indexed by draw order.
package menu_pkg;

   localparam int MENU_NUM_SPRITES = 8;
   localparam int MENU_TOTAL_PIXELS = 26800;

   localparam logic [2:0] FG_COLOUR    = 3'b111;
   localparam logic [2:0] HI_COLOUR    = 3'b110;
   localparam logic [2:0] TITLE_COLOUR = 3'b100;
   localparam logic [2:0] BG_COLOUR    = 3'b000;

   localparam logic [8:0] CLEAR_X_LAST = 9'd319;
   localparam logic [7:0] CLEAR_Y_LAST = 8'd239;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DRAW,
      ST_FLUSH,
      ST_DONE
   } menu_state_t;

   function automatic logic [6:0] sprite_w(input logic [2:0] idx);
      case (idx)
         3'd0:             sprite_w = 7'd120;
         3'd1, 3'd2, 3'd3: sprite_w = 7'd80;
         default:          sprite_w = 7'd20;
      endcase
   endfunction

   function automatic logic [6:0] sprite_h(input logic [2:0] idx);
      case (idx)
         3'd0:             sprite_h = 7'd50;
         3'd1, 3'd2, 3'd3: sprite_h = 7'd80;
         default:          sprite_h = 7'd20;
      endcase
   endfunction

   function automatic logic [8:0] sprite_x0(input logic [2:0] idx);
      case (idx)
         3'd0:    sprite_x0 = 9'd100;
         3'd1:    sprite_x0 = 9'd20;
         3'd2:    sprite_x0 = 9'd120;
         3'd3:    sprite_x0 = 9'd220;
         3'd4:    sprite_x0 = 9'd50;
         3'd5:    sprite_x0 = 9'd150;
         3'd6:    sprite_x0 = 9'd250;
         default: sprite_x0 = 9'd150;
      endcase
   endfunction

   function automatic logic [7:0] sprite_y0(input logic [2:0] idx);
      case (idx)
         3'd0:             sprite_y0 = 8'd10;
         3'd1, 3'd2, 3'd3: sprite_y0 = 8'd80;
         3'd4, 3'd5, 3'd6: sprite_y0 = 8'd170;
         default:          sprite_y0 = 8'd210;
      endcase
   endfunction

   // Each sprite lives in its own ROM; the q bus is ordered to match draw order.
   function automatic logic [2:0] sprite_rom_bit(input logic [2:0] idx);
      sprite_rom_bit = idx;
   endfunction

endpackage

// File: rtl/menu_sprite_walker.sv
// Row-major col/row/address counters that step through every sprite in order.
// 'last' flags the final pixel of the final sprite so the FSM can stop issuing.
module menu_sprite_walker
   import menu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   output logic [12:0] addr,
   output logic [6:0]  col,
   output logic [6:0]  row,
   output logic [2:0]  sprite,
   output logic        last
);

   logic col_end;
   logic row_end;

   assign col_end = (col == sprite_w(sprite) - 7'd1);
   assign row_end = (row == sprite_h(sprite) - 7'd1);
   assign last    = col_end && row_end && (sprite == 3'(MENU_NUM_SPRITES - 1));

   // The address runs continuously across rows and restarts at 0 for each new
   // sprite, so the next sprite begins on the very next cycle.
   always_ff @(posedge clock) begin
      if (reset || load) begin
         addr   <= '0;
         col    <= '0;
         row    <= '0;
         sprite <= '0;
      end else if (advance) begin
         if (!col_end) begin
            col  <= col + 7'd1;
            addr <= addr + 13'd1;
         end else begin
            col <= '0;
            if (!row_end) begin
               row  <= row + 7'd1;
               addr <= addr + 13'd1;
            end else begin
               row    <= '0;
               addr   <= '0;
               sprite <= sprite + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/menu_blit_ctrl.sv
// Menu screen blitter: walks the sprite table, reads the 1-bit sprite ROMs and
// plots coloured pixels. Define MENU_CLEAR_EN to clear the framebuffer first.
module menu_blit_ctrl
   import menu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  sel,
   output logic [12:0] rom_addr,
   input  logic [7:0]  rom_q,
   output logic [8:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        plot,
   output logic        busy,
   output logic        done
);

   menu_state_t state;
   menu_state_t state_next;

   logic [1:0] sel_q;
   logic       walk_load;
   logic       walk_advance;
   logic       draw_issue;
   logic [6:0] walk_col;
   logic [6:0] walk_row;
   logic [2:0] walk_sprite;
   logic       walk_last;

   logic [2:0] pipe_sprite;
   logic       pipe_bg;
   logic       pix_bit;
   logic [2:0] hi_icon;
   logic [2:0] hi_caption;

`ifdef MENU_CLEAR_EN
   logic [8:0] clear_x;
   logic [7:0] clear_y;
   logic       clear_issue;
   logic       clear_last;

   assign clear_last = (clear_x == CLEAR_X_LAST) && (clear_y == CLEAR_Y_LAST);

   // Full-screen raster used to blank the framebuffer before the sprites land.
   always_ff @(posedge clock) begin
      if (reset || walk_load) begin
         clear_x <= '0;
         clear_y <= '0;
      end else if (clear_issue) begin
         if (clear_x == CLEAR_X_LAST) begin
            clear_x <= '0;
            clear_y <= clear_y + 8'd1;
         end else begin
            clear_x <= clear_x + 9'd1;
         end
      end
   end
`endif

   menu_sprite_walker u_walker (
      .clock   (clock),
      .reset   (reset),
      .load    (walk_load),
      .advance (walk_advance),
      .addr    (rom_addr),
      .col     (walk_col),
      .row     (walk_row),
      .sprite  (walk_sprite),
      .last    (walk_last)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         sel_q <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && start) begin
            sel_q <= (sel == 2'd3) ? 2'd0 : sel;
         end
      end
   end

   always_comb begin
      state_next   = state;
      walk_load    = 1'b0;
      walk_advance = 1'b0;
      draw_issue   = 1'b0;
`ifdef MENU_CLEAR_EN
      clear_issue  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (start) begin
               walk_load = 1'b1;
`ifdef MENU_CLEAR_EN
               state_next = ST_CLEAR;
`else
               state_next = ST_DRAW;
`endif
            end
         end
`ifdef MENU_CLEAR_EN
         ST_CLEAR: begin
            clear_issue = 1'b1;
            if (clear_last) begin
               state_next = ST_DRAW;
            end
         end
`endif
         ST_DRAW: begin
            walk_advance = 1'b1;
            draw_issue   = 1'b1;
            if (walk_last) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output stage lines up coordinates with the ROM data that arrives one cycle
   // after its address was issued.
   always_ff @(posedge clock) begin
      if (reset) begin
         plot        <= 1'b0;
         vga_x       <= '0;
         vga_y       <= '0;
         pipe_sprite <= '0;
         pipe_bg     <= 1'b0;
      end else begin
         plot    <= 1'b0;
         pipe_bg <= 1'b0;
         if (draw_issue) begin
            plot        <= 1'b1;
            vga_x       <= sprite_x0(walk_sprite) + {2'b00, walk_col};
            vga_y       <= sprite_y0(walk_sprite) + {1'b0, walk_row};
            pipe_sprite <= walk_sprite;
         end
`ifdef MENU_CLEAR_EN
         else if (clear_issue) begin
            plot    <= 1'b1;
            vga_x   <= clear_x;
            vga_y   <= clear_y;
            pipe_bg <= 1'b1;
         end
`endif
      end
   end

   assign pix_bit    = rom_q[sprite_rom_bit(pipe_sprite)];
   assign hi_icon    = 3'd1 + {1'b0, sel_q};
   assign hi_caption = 3'd4 + {1'b0, sel_q};

   // The highlighted game recolours both its icon and its caption.
   always_comb begin
      vga_colour = 3'b000;
      if (plot) begin
         if (pipe_bg || !pix_bit) begin
            vga_colour = BG_COLOUR;
         end else if (pipe_sprite == 3'd0) begin
            vga_colour = TITLE_COLOUR;
         end else if (pipe_sprite == hi_icon || pipe_sprite == hi_caption) begin
            vga_colour = HI_COLOUR;
         end else begin
            vga_colour = FG_COLOUR;
         end
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule
